activation_mem_ctrl: RTL and testbench
======================================

ACTIVATION_MEM_CTRL -- requirements
Module: activation_mem_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 8, systolic array dimension.
REQ-002 SHALL have parameter MEM_SIZE, default SIZE*SIZE, activation words per tile.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(MEM_SIZE), activation memory address width.
REQ-004 SHALL have parameter CAL_CYCLES, default 3*SIZE-1, Cal duration: SIZE feed cycles plus skew drain.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  begin loading a new tile; sampled only in IDLE.
REQ-008 SHALL have port act_in  input  7  activation stream data.
REQ-009 SHALL have port act_in_valid  input  1  act_in is valid.
REQ-010 SHALL have port act_in_ready  output  1  controller accepts a beat.
REQ-011 SHALL have port weight_ready  input  1  systolic array weights loaded; level signal.
REQ-012 SHALL have port Activation  output  7  write data to activation memory.
REQ-013 SHALL have port Activation_Mem_Address_in  output  ADDR_WIDTH  write address to activation memory.
REQ-014 SHALL have port load_mem_done  output  1  low = memory writes every cycle; high = load complete.
REQ-015 SHALL have port Cal  output  1  compute phase; memory advances its read row each cycle.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port tile_done  output  1  one-cycle pulse at end of a tile.

Function
REQ-018 SHALL implement states IDLE, LOAD, FLUSH, WAIT, CAL, DONE in a registered state machine.
REQ-019 SHALL transition IDLE->LOAD when start=1; start in any other state is ignored.
REQ-020 SHALL drive act_in_ready=1 only in LOAD; a beat is accepted when act_in_valid & act_in_ready.
REQ-021 SHALL, on each accepted beat, register act_in into Activation and the beat index (0 for first beat of tile, incrementing) into Activation_Mem_Address_in.
REQ-022 SHALL hold Activation and Activation_Mem_Address_in unchanged on cycles without an accepted beat, so repeated memory writes are idempotent.
REQ-023 SHALL tolerate act_in_valid gaps of any length in LOAD with no lost or duplicated addresses.
REQ-024 SHALL transition LOAD->FLUSH on the cycle the MEM_SIZE-th beat (address MEM_SIZE-1) is accepted; FLUSH lasts exactly one cycle, then WAIT.
REQ-025 SHALL drive load_mem_done=0 in LOAD and FLUSH, 1 in all other states, decoded from the state register only.
REQ-026 SHALL transition WAIT->CAL on the first cycle weight_ready=1 in WAIT; if weight_ready is already 1 on entry, CAL follows after one WAIT cycle.
REQ-027 SHALL drive Cal=1 for exactly CAL_CYCLES consecutive cycles in CAL, counted by an internal counter cleared on CAL entry.
REQ-028 SHALL transition CAL->DONE after the CAL_CYCLES-th Cal cycle; DONE lasts one cycle with tile_done=1, then IDLE.
REQ-029 SHALL drive Cal=0 in every state other than CAL; Cal and load_mem_done=0 never coincide.
REQ-030 SHALL ignore weight_ready outside WAIT and act_in_valid outside LOAD.
REQ-031 SHALL restart the beat index at 0 for each new tile; the index never exceeds MEM_SIZE-1.

Reset
REQ-032 SHALL, when rst=1 at a rising edge, in any state including mid-LOAD or mid-CAL, enter IDLE with act_in_ready=0, Activation=0, Activation_Mem_Address_in=0, load_mem_done=1, Cal=0, busy=0, tile_done=0, and all counters 0.
REQ-033 SHALL give rst priority over start and all other inputs on the same edge.

Verification
REQ-034 SHALL verify: reset, start pulse, 64 back-to-back beats act_in=k&7'h7F, weight_ready=1 -> addresses 0..63 in order, load_mem_done low 65 cycles, WAIT 1 cycle, Cal high exactly 23 cycles, tile_done pulses once, IDLE.
REQ-035 SHALL verify: random act_in_valid gaps (~50% duty) -> every address 0..63 written once with correct data; address/data held across gaps.
REQ-036 SHALL verify: weight_ready held 0 for 100 cycles after load -> controller stays in WAIT, load_mem_done=1, Cal=0; on weight_ready=1 Cal starts next cycle.
REQ-037 SHALL verify: rst asserted at beat 30 of LOAD and at Cal cycle 10 -> all outputs at REQ-032 values next cycle; following tile restarts from address 0.
REQ-038 SHALL verify: start asserted during LOAD, WAIT and CAL -> no state change, no extra tile; two consecutive tiles produce two tile_done pulses.

Source files
------------

// File: rtl/activation_mem_ctrl_if.sv
// Handshake and memory-side signal bundle for the activation memory controller.
// The controller side uses the slave modport; the stream source and memory side use master.
interface activation_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic [6:0]            act_in;
  logic                  act_in_valid;
  logic                  act_in_ready;
  logic                  weight_ready;
  logic [6:0]            Activation;
  logic [ADDR_WIDTH-1:0] Activation_Mem_Address_in;
  logic                  load_mem_done;
  logic                  Cal;
  logic                  busy;
  logic                  tile_done;

  modport master (
    output start, act_in, act_in_valid, weight_ready,
    input  act_in_ready, Activation, Activation_Mem_Address_in,
           load_mem_done, Cal, busy, tile_done
  );

  modport slave (
    input  start, act_in, act_in_valid, weight_ready,
    output act_in_ready, Activation, Activation_Mem_Address_in,
           load_mem_done, Cal, busy, tile_done
  );
endinterface

// File: rtl/activation_mem_ctrl.sv
// Loads one tile of activations into memory, waits for weights, then runs the
// compute phase for CAL_CYCLES cycles and pulses tile_done.
module activation_mem_ctrl #(
  parameter int SIZE       = 8,
  parameter int MEM_SIZE   = SIZE * SIZE,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int CAL_CYCLES = 3 * SIZE - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  activation_mem_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    WAIT,
    CAL,
    DONE
  } state_t;

  typedef struct packed {
    logic ready;
    logic ldone;
    logic cal;
    logic busy;
    logic done;
  } ctrl_t;

  localparam int                    CNT_W     = $clog2(CAL_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [CNT_W-1:0]      LAST_CAL  = CNT_W'(CAL_CYCLES - 1);

  state_t                state;
  ctrl_t                 ctrl;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic [CNT_W-1:0]      cal_cnt;
  logic                  beat_accept;

  // Output pattern is a pure function of the state being entered, so every
  // registered output always agrees with the state register.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c.ready = (s == LOAD);
    c.ldone = (s != LOAD) && (s != FLUSH);
    c.cal   = (s == CAL);
    c.busy  = (s != IDLE);
    c.done  = (s == DONE);
    return c;
  endfunction

  always_comb begin
    beat_accept = bus.act_in_valid & ctrl.ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                         <= IDLE;
      ctrl                          <= ctrl_for(IDLE);
      beat_cnt                      <= '0;
      cal_cnt                       <= '0;
      bus.Activation                <= '0;
      bus.Activation_Mem_Address_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= LOAD;
            ctrl     <= ctrl_for(LOAD);
            beat_cnt <= '0;
          end
        end
        LOAD: begin
          if (beat_accept) begin
            bus.Activation                <= bus.act_in;
            bus.Activation_Mem_Address_in <= beat_cnt;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= FLUSH;
              ctrl     <= ctrl_for(FLUSH);
            end else begin
              beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
            end
          end
        end
        // One extra write cycle so the memory captures the last beat.
        FLUSH: begin
          state <= WAIT;
          ctrl  <= ctrl_for(WAIT);
        end
        WAIT: begin
          if (bus.weight_ready) begin
            state   <= CAL;
            ctrl    <= ctrl_for(CAL);
            cal_cnt <= '0;
          end
        end
        CAL: begin
          if (cal_cnt == LAST_CAL) begin
            cal_cnt <= '0;
            state   <= DONE;
            ctrl    <= ctrl_for(DONE);
          end else begin
            cal_cnt <= cal_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          ctrl  <= ctrl_for(IDLE);
        end
        default: begin
          state <= IDLE;
          ctrl  <= ctrl_for(IDLE);
        end
      endcase
    end
  end

  assign bus.act_in_ready  = ctrl.ready;
  assign bus.load_mem_done = ctrl.ldone;
  assign bus.Cal           = ctrl.cal;
  assign bus.busy          = ctrl.busy;
  assign bus.tile_done     = ctrl.done;

  a_cal_not_loading: assert property (@(posedge clk) disable iff (rst)
    !(ctrl.cal && !ctrl.ldone));

  a_beat_in_range: assert property (@(posedge clk) disable iff (rst)
    beat_cnt <= LAST_BEAT);

endmodule

// File: tb/tb_activation_mem_ctrl.sv
// Scoreboard bench for activation_mem_ctrl: stimulus queues expected memory
// writes and per-tile phase lengths; a negedge monitor pops and compares them.
module tb_activation_mem_ctrl;

  localparam int AW    = 6;
  localparam int NBEAT = 64;
  localparam int NCAL  = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  activation_mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  activation_mem_ctrl #(
    .SIZE       (8),
    .MEM_SIZE   (NBEAT),
    .ADDR_WIDTH (AW),
    .CAL_CYCLES (NCAL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [6:0]    data;
  } beat_t;

  typedef struct {
    int low;
    int wt;
    int cal;
    int bsy;
  } tile_t;

  beat_t exp_q[$];
  tile_t tile_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] beat_data(input int k, input bit alt);
    int v;
    v = alt ? ((k * 37 + 5) % 128) : (k % 128);
    return 7'(v);
  endfunction

  // Monitor: one pass per negedge, comparing what the last rising edge produced.
  initial begin : monitor
    bit    hs_pend  = 1'b0;
    bit    rst_pend = 1'b0;
    beat_t last     = '0;
    beat_t e;
    tile_t t;
    int    n_low = 0, n_wt = 0, n_cal = 0, n_bsy = 0;
    forever begin
      @(negedge clk);
      if (rst_pend) begin
        chk("rst_ready", bus.act_in_ready, 0);
        chk("rst_activation", bus.Activation, 0);
        chk("rst_addr", bus.Activation_Mem_Address_in, 0);
        chk("rst_load_mem_done", bus.load_mem_done, 1);
        chk("rst_cal", bus.Cal, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tile_done", bus.tile_done, 0);
        last = '0;
      end else if (hs_pend) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got addr %0d with no write pending", bus.Activation_Mem_Address_in);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", bus.Activation_Mem_Address_in, e.addr);
          chk("beat_data", bus.Activation, e.data);
          last = e;
        end
      end else begin
        chk("hold_addr", bus.Activation_Mem_Address_in, last.addr);
        chk("hold_data", bus.Activation, last.data);
      end
      chk("cal_while_loading", bus.Cal & ~bus.load_mem_done, 0);
      chk("ready_outside_load", bus.act_in_ready & bus.load_mem_done, 0);

      if (bus.load_mem_done === 1'b0) n_low++;
      if (bus.Cal === 1'b1) n_cal++;
      if (bus.busy === 1'b1) n_bsy++;
      if (bus.busy === 1'b1 && bus.load_mem_done === 1'b1 && bus.Cal === 1'b0 && bus.tile_done === 1'b0) n_wt++;

      if (bus.tile_done === 1'b1) begin
        if (tile_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_tile_done: got pulse with no tile pending");
        end else begin
          t = tile_q.pop_front();
          chk("load_low_cycles", n_low, t.low);
          chk("wait_cycles", n_wt, t.wt);
          chk("cal_cycles", n_cal, t.cal);
          chk("busy_cycles", n_bsy, t.bsy);
        end
        n_low = 0; n_wt = 0; n_cal = 0; n_bsy = 0;
      end

      hs_pend  = (bus.act_in_valid === 1'b1) && (bus.act_in_ready === 1'b1) && !rst;
      rst_pend = rst;
      if (rst) begin
        n_low = 0; n_wt = 0; n_cal = 0; n_bsy = 0;
      end
    end
  end

  task automatic run_tile(input bit gaps, input int stall, input bit poke);
    int    g  = 0;
    int    cc = 0;
    bit    seen = 1'b0;
    tile_t t;
    for (int k = 0; k < NBEAT; k++) exp_q.push_back('{addr: AW'(k), data: beat_data(k, gaps)});
    bus.weight_ready = (stall == 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < NBEAT; k++) begin
      for (int n = 0; gaps && n < 4 && $urandom_range(0, 1) == 1; n++) begin
        bus.act_in_valid = 1'b0;
        bus.act_in       = 7'h55;
        step();
        g++;
      end
      bus.act_in_valid = 1'b1;
      bus.act_in       = beat_data(k, gaps);
      bus.start        = poke && (k == 10);
      step();
      bus.start = 1'b0;
    end
    bus.act_in_valid = 1'b0;
    t.low = NBEAT + 1 + g;
    t.wt  = (stall == 0) ? 1 : stall;
    t.cal = NCAL;
    t.bsy = t.low + t.wt + t.cal + 1;
    tile_q.push_back(t);
    for (int i = 0; i < stall; i++) begin
      bus.start = poke && (i == 2);
      step();
      bus.start = 1'b0;
    end
    bus.weight_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      bus.start = 1'b0;
      if (bus.tile_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (poke && bus.Cal === 1'b1) begin
        cc++;
        if (cc == 3) bus.start = 1'b1;
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL tile_done_timeout: got no pulse within 200 cycles");
    end
    step();
    chk("idle_after_tile", bus.busy, 0);
    if (poke) begin
      repeat (3) step();
      chk("idle_after_ignored_start", bus.busy, 0);
    end
    chk("beats_left", exp_q.size(), 0);
  endtask

  task automatic abort_tile(input bit in_cal);
    int nb;
    bit seen = 1'b0;
    nb = in_cal ? NBEAT : 30;
    for (int k = 0; k < nb; k++) exp_q.push_back('{addr: AW'(k), data: beat_data(k, 1'b1)});
    bus.weight_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < nb; k++) begin
      bus.act_in_valid = 1'b1;
      bus.act_in       = beat_data(k, 1'b1);
      step();
    end
    if (in_cal) begin
      bus.act_in_valid = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (bus.Cal === 1'b1) begin
          seen = 1'b1;
          break;
        end
        step();
      end
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL cal_timeout: got no Cal within 200 cycles");
      end
      repeat (9) step();
    end else begin
      bus.act_in = beat_data(30, 1'b1);
    end
    rst       = 1'b1;
    bus.start = 1'b1;
    step();
    rst              = 1'b0;
    bus.start        = 1'b0;
    bus.act_in_valid = 1'b0;
    step();
    chk("beats_left_after_abort", exp_q.size(), 0);
  endtask

  initial begin : stimulus
    bus.start        = 1'b0;
    bus.act_in       = '0;
    bus.act_in_valid = 1'b0;
    bus.weight_ready = 1'b0;
    rst              = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    run_tile(1'b0, 0, 1'b0);
    run_tile(1'b1, 0, 1'b0);
    run_tile(1'b0, 100, 1'b0);
    abort_tile(1'b0);
    run_tile(1'b0, 0, 1'b0);
    abort_tile(1'b1);
    run_tile(1'b0, 0, 1'b0);
    run_tile(1'b1, 5, 1'b1);
    run_tile(1'b0, 0, 1'b0);

    repeat (3) step();
    chk("beats_left_final", exp_q.size(), 0);
    chk("tiles_left_final", tile_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
